// File: rtl/halfword_flag_encoder.sv
// Encodes 2-bit flag requests into 32-bit words for the half-word "equals one" checker,
// with a single registered output stage, expected checker result and sequence tag.
module halfword_flag_encoder #(
    parameter logic [15:0] FILLER_INIT = 16'h0002,
    parameter logic [15:0] FILLER_STEP = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  din_flags,
    input  logic        din_vld,
    output logic        din_rd,
    output logic [31:0] dout_data,
    output logic        dout_b,
    output logic [15:0] dout_seq,
    output logic        dout_vld,
    input  logic        dout_rd,
    output logic [15:0] words_sent
);

    localparam int unsigned HW = 16;
    localparam int unsigned DW = 32;
    localparam logic [HW-1:0] MATCH      = HW'(1);
    localparam logic [HW-1:0] FILLER_RST = (FILLER_INIT == MATCH) ? HW'(2) : FILLER_INIT;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   dout_data_q, dout_data_d;
    logic            dout_b_q, dout_b_d;
    logic [HW-1:0]   dout_seq_q, dout_seq_d;
    logic [HW-1:0]   words_sent_q, words_sent_d;
    logic [HW-1:0]   filler_q, filler_d;
    logic [HW-1:0]   seq_q, seq_d;
    logic [HW-1:0]   filler_inc;
    logic [HW-1:0]   filler_next;
    logic            accept;
    logic            out_hs;

    assign din_rd     = (state_q == EMPTY) | dout_rd;
    assign dout_vld   = (state_q == FULL);
    assign dout_data  = dout_data_q;
    assign dout_b     = dout_b_q;
    assign dout_seq   = dout_seq_q;
    assign words_sent = words_sent_q;

    // One extra step always escapes 16'h0001 because the step is non-zero.
    always_comb begin
        filler_inc  = filler_q + FILLER_STEP;
        filler_next = (filler_inc == MATCH) ? HW'(filler_inc + FILLER_STEP) : filler_inc;
    end

    always_comb begin
        state_d      = state_q;
        dout_data_d  = dout_data_q;
        dout_b_d     = dout_b_q;
        dout_seq_d   = dout_seq_q;
        words_sent_d = words_sent_q;
        filler_d     = filler_q;
        seq_d        = seq_q;

        accept = din_vld & din_rd;
        out_hs = (state_q == FULL) & dout_rd;

        if (out_hs) begin
            words_sent_d = words_sent_q + HW'(1);
            state_d      = EMPTY;
        end

        if (accept) begin
            dout_data_d[31:16] = din_flags[1] ? MATCH : filler_q;
            dout_data_d[15:0]  = din_flags[0] ? MATCH : filler_q;
            dout_b_d           = ~(din_flags[1] & din_flags[0]);
            dout_seq_d         = seq_q;
            seq_d              = seq_q + HW'(1);
            filler_d           = filler_next;
            state_d            = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            dout_data_q  <= '0;
            dout_b_q     <= 1'b0;
            dout_seq_q   <= '0;
            words_sent_q <= '0;
            filler_q     <= FILLER_RST;
            seq_q        <= '0;
        end else begin
            state_q      <= state_d;
            dout_data_q  <= dout_data_d;
            dout_b_q     <= dout_b_d;
            dout_seq_q   <= dout_seq_d;
            words_sent_q <= words_sent_d;
            filler_q     <= filler_d;
            seq_q        <= seq_d;
        end
    end

endmodule

// File: tb/tb_halfword_flag_encoder.sv
// Bench for halfword_flag_encoder: queue-based reference model, per-cycle compare,
// directed literal vectors and a long random loopback run through a checker model.
module tb_halfword_flag_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  din_flags = 2'b00;
    logic        din_vld = 1'b0;
    logic        dout_rd = 1'b0;

    logic        din_rd;
    logic [31:0] dout_data;
    logic        dout_b;
    logic [15:0] dout_seq;
    logic        dout_vld;
    logic [15:0] words_sent;

    logic        din_rd2, dout_b2, dout_vld2, din_rd3, dout_b3, dout_vld3;
    logic [31:0] dout_data2, dout_data3;
    logic [15:0] dout_seq2, words_sent2, dout_seq3, words_sent3;

    always #5 clk = ~clk;

    halfword_flag_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .din_flags(din_flags), .din_vld(din_vld), .din_rd(din_rd),
        .dout_data(dout_data), .dout_b(dout_b), .dout_seq(dout_seq), .dout_vld(dout_vld),
        .dout_rd(dout_rd), .words_sent(words_sent)
    );

    halfword_flag_encoder #(.FILLER_INIT(16'hFFFF), .FILLER_STEP(16'h0001)) u_dut_ffff (
        .clk(clk), .rst_n(rst_n), .din_flags(din_flags), .din_vld(din_vld), .din_rd(din_rd2),
        .dout_data(dout_data2), .dout_b(dout_b2), .dout_seq(dout_seq2), .dout_vld(dout_vld2),
        .dout_rd(dout_rd), .words_sent(words_sent2)
    );

    halfword_flag_encoder #(.FILLER_INIT(16'h0001), .FILLER_STEP(16'h0001)) u_dut_one (
        .clk(clk), .rst_n(rst_n), .din_flags(din_flags), .din_vld(din_vld), .din_rd(din_rd3),
        .dout_data(dout_data3), .dout_b(dout_b3), .dout_seq(dout_seq3), .dout_vld(dout_vld3),
        .dout_rd(dout_rd), .words_sent(words_sent3)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        b;
        logic [15:0] s;
    } word_t;

    int          errors = 0;
    int          checks = 0;
    word_t       mq[$];
    logic [15:0] m_fill;
    logic [15:0] m_seq;
    logic [15:0] m_sent;
    int          total_hs;
    int          total_acc;
    logic [15:0] prev_hs_seq;
    bit          seen_wrap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] next_fill(input logic [15:0] f);
        logic [15:0] n;
        n = f + 16'h0001;
        while (n == 16'h0001) n = n + 16'h0001;
        return n;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fill      = 16'h0002;
        m_seq       = 16'h0000;
        m_sent      = 16'h0000;
        total_hs    = 0;
        total_acc   = 0;
        prev_hs_seq = 16'h0000;
        seen_wrap   = 1'b0;
    endtask

    // Advances the model on a clock edge using the inputs that were stable before it.
    task automatic model_edge();
        bit    hs;
        bit    acc;
        word_t w;
        hs  = (mq.size() != 0) && dout_rd;
        acc = din_vld && ((mq.size() == 0) || dout_rd);
        if (hs) begin
            void'(mq.pop_front());
            m_sent = m_sent + 16'h0001;
            total_hs++;
        end
        if (acc) begin
            w.d[31:16] = din_flags[1] ? 16'h0001 : m_fill;
            w.d[15:0]  = din_flags[0] ? 16'h0001 : m_fill;
            w.b        = !(din_flags == 2'b11);
            w.s        = m_seq;
            mq.push_back(w);
            m_seq  = m_seq + 16'h0001;
            m_fill = next_fill(m_fill);
            total_acc++;
        end
    endtask

    task automatic compare();
        logic exp_vld;
        logic dec_b;
        exp_vld = (mq.size() != 0);
        chk("dout_vld", 32'(dout_vld), 32'(exp_vld));
        chk("din_rd", 32'(din_rd), 32'(!exp_vld || dout_rd));
        chk("words_sent", 32'(words_sent), 32'(m_sent));
        if (exp_vld) begin
            chk("dout_data", dout_data, mq[0].d);
            chk("dout_b", 32'(dout_b), 32'(mq[0].b));
            chk("dout_seq", 32'(dout_seq), 32'(mq[0].s));
            dec_b = !((dout_data[31:16] == 16'h0001) && (dout_data[15:0] == 16'h0001));
            chk("loopback_b", 32'(dout_b), 32'(dec_b));
            if (dout_rd) begin
                if (prev_hs_seq == 16'hFFFF && dout_seq == 16'h0000) seen_wrap = 1'b1;
                prev_hs_seq = dout_seq;
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        compare();
    endtask

    task automatic pos();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [1:0] f, input logic v, input logic r);
        din_flags = f;
        din_vld   = v;
        dout_rd   = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(2'b00, 1'b0, 1'b0);
        model_reset();
        neg();
        chk("rst_vld", 32'(dout_vld), 32'd0);
        chk("rst_data", dout_data, 32'h0);
        chk("rst_seq", 32'(dout_seq), 32'd0);
        chk("rst_sent", 32'(words_sent), 32'd0);
        pos();
        rst_n = 1'b1;
    endtask

    int cyc;

    initial begin
        model_reset();
        pos();
        do_reset();

        // Both flags set: word 00010001, b=0, seq 0, then drained.
        set_in(2'b11, 1'b1, 1'b1);
        neg(); pos();
        set_in(2'b00, 1'b0, 1'b1);
        neg();
        chk("t1_data", dout_data, 32'h00010001);
        chk("t1_b", 32'(dout_b), 32'd0);
        chk("t1_seq", 32'(dout_seq), 32'd0);
        pos(); neg();
        chk("t1_vld_low", 32'(dout_vld), 32'd0);
        chk("t1_sent", 32'(words_sent), 32'd1);
        pos();

        // Back-to-back 00, 10, 01.
        do_reset();
        set_in(2'b00, 1'b1, 1'b1); neg(); pos();
        set_in(2'b10, 1'b1, 1'b1); neg();
        chk("t2_w0", dout_data, 32'h00020002);
        chk("t2_b0", 32'(dout_b), 32'd1);
        chk("t2_s0", 32'(dout_seq), 32'd0);
        pos();
        set_in(2'b01, 1'b1, 1'b1); neg();
        chk("t2_w1", dout_data, 32'h00010003);
        chk("t2_s1", 32'(dout_seq), 32'd1);
        pos();
        set_in(2'b00, 1'b0, 1'b1); neg();
        chk("t2_w2", dout_data, 32'h00040001);
        chk("t2_b2", 32'(dout_b), 32'd1);
        chk("t2_s2", 32'(dout_seq), 32'd2);
        pos(); neg();
        chk("t2_sent", 32'(words_sent), 32'd3);
        pos();

        // Backpressure for 5 cycles with a pending request.
        set_in(2'b00, 1'b1, 1'b0); neg(); pos();
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("t3_din_rd", 32'(din_rd), 32'd0);
            chk("t3_data", dout_data, 32'h00050005);
            chk("t3_seq", 32'(dout_seq), 32'd3);
            pos();
        end
        set_in(2'b00, 1'b1, 1'b1); neg(); pos();
        set_in(2'b00, 1'b0, 1'b1); neg();
        chk("t3_next", dout_data, 32'h00060006);
        chk("t3_next_seq", 32'(dout_seq), 32'd4);
        pos(); neg();
        chk("t3_sent", 32'(words_sent), 32'd5);
        pos();

        // Filler wrap skipping 0001, and forced reset filler when FILLER_INIT is 0001.
        do_reset();
        set_in(2'b00, 1'b1, 1'b1); neg(); pos();
        neg();
        chk("t4_ffff_w0", dout_data2, 32'hFFFFFFFF);
        chk("t4_one_w0", dout_data3, 32'h00020002);
        pos(); neg();
        chk("t4_ffff_w1", dout_data2, 32'h00000000);
        chk("t4_one_w1", dout_data3, 32'h00030003);
        pos();
        set_in(2'b00, 1'b0, 1'b1); neg();
        chk("t4_ffff_w2", dout_data2, 32'h00020002);
        chk("t4_one_w2", dout_data3, 32'h00040004);
        pos();

        // Asynchronous reset mid-stream while stalled.
        set_in(2'b01, 1'b1, 1'b0); neg(); pos();
        neg(); pos();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_vld_async", 32'(dout_vld), 32'd0);
        chk("t5_data_async", dout_data, 32'h0);
        chk("t5_sent_async", 32'(words_sent), 32'd0);
        set_in(2'b00, 1'b0, 1'b0);
        neg(); pos();
        rst_n = 1'b1;
        set_in(2'b00, 1'b1, 1'b1); neg(); pos();
        set_in(2'b00, 1'b0, 1'b1); neg();
        chk("t5_first", dout_data, 32'h00020002);
        chk("t5_first_seq", 32'(dout_seq), 32'd0);
        pos();

        // Random loopback long enough to wrap both 16-bit counters.
        do_reset();
        cyc = 0;
        while (total_acc < 70000 && cyc < 90000) begin
            set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 31) != 0),
                   1'($urandom_range(0, 15) != 0));
            neg(); pos();
            cyc++;
        end
        chk("rand_budget", 32'(total_acc >= 70000), 32'd1);
        set_in(2'b00, 1'b0, 1'b1);
        neg(); pos();
        neg();
        chk("rand_sent_final", 32'(words_sent), 32'(total_hs[15:0]));
        chk("rand_seq_wrap", 32'(seen_wrap), 32'd1);
        chk("rand_drained", 32'(dout_vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
